// File: rtl/store_unit.sv
// store_unit: takes one store request, builds the aligned bus address, lane-shifted data and
// byte enables, and issues one beat (or two when the access crosses a word boundary).
//
//   state | meaning
//   IDLE  | ready for a request; illegal or rejected requests pulse err_o here
//   BEAT1 | first (or only) bus beat presented, waiting for mem_ready_i
//   BEAT2 | upper-word beat of a boundary-crossing store, waiting for mem_ready_i
module store_unit #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   data_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

    state_t              state;
    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [NB-1:0]       be_q;
    logic                done_q;
    logic                err_q;
    logic                split_q;
    logic [XLEN-1:0]     wdata_hi_q;
    logic [NB-1:0]       be_hi_q;

    logic [3:0]          sz;
    logic [OFF_W-1:0]    off;
    logic [NB-1:0]       mask_lo;
    logic [XLEN-1:0]     data_m;
    logic [2*NB-1:0]     be2;
    logic [2*XLEN-1:0]   d2;
    logic                split;
    logic                illegal;
    logic                reject;

    assign off = addr_i[OFF_W-1:0];

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   sz = 4'd1;
            2'b01:   sz = 4'd2;
            2'b10:   sz = 4'd4;
            default: sz = 4'd8;
        endcase
    end

    // Bytes beyond the access size are zeroed before shifting so unused lanes stay zero.
    always_comb begin
        mask_lo = '0;
        data_m  = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(sz)) begin
                mask_lo[i]       = 1'b1;
                data_m[8*i +: 8] = data_i[8*i +: 8];
            end
        end
        be2 = {{NB{1'b0}}, mask_lo} << off;
        d2  = {{XLEN{1'b0}}, data_m} << {off, 3'b000};
    end

    assign split   = (int'(off) + int'(sz)) > NB;
    assign illegal = funct3_i[2] || ((funct3_i[1:0] == 2'b11) && (XLEN == 32));
    assign reject  = illegal || (split && !ALLOW_MISALIGNED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            split_q    <= 1'b0;
            wdata_hi_q <= '0;
            be_hi_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state      <= BEAT1;
                            valid_q    <= 1'b1;
                            addr_q     <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            wdata_q    <= d2[XLEN-1:0];
                            be_q       <= be2[NB-1:0];
                            split_q    <= split;
                            wdata_hi_q <= d2[2*XLEN-1:XLEN];
                            be_hi_q    <= be2[2*NB-1:NB];
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready_i) begin
                        if (split_q) begin
                            state   <= BEAT2;
                            addr_q  <= addr_q + ADDR_W'(NB);
                            wdata_q <= wdata_hi_q;
                            be_q    <= be_hi_q;
                        end else begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                BEAT2: begin
                    if (mem_ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: drives three store_unit configurations (32-bit split, 32-bit reject,
// 64-bit split) with the same requests and compares every cycle against a byte-level model.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [63:0] din = 64'd0;

    logic [2:0]        mv, rr, dn, er;
    logic [2:0][31:0]  ma;
    logic [31:0]       wd_a, wd_b;
    logic [63:0]       wd_c;
    logic [3:0]        be_a, be_b;
    logic [7:0]        be_c;

    int tests = 0;
    int fails = 0;

    bit          m_err [3];
    int          m_nb  [3];
    logic [31:0] m_addr[3][2];
    logic [7:0]  m_be  [3][2];
    logic [63:0] m_wd  [3][2];
    int          idx   [3];
    bit          done_p[3];
    bit          err_p [3];

    always #5 clk = ~clk;

    store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr[0]),
        .funct3_i(f3), .addr_i(addr), .data_i(din[31:0]),
        .mem_valid_o(mv[0]), .mem_ready_i(mem_ready), .mem_addr_o(ma[0]),
        .mem_wdata_o(wd_a), .mem_be_o(be_a), .done_o(dn[0]), .err_o(er[0]));

    store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr[1]),
        .funct3_i(f3), .addr_i(addr), .data_i(din[31:0]),
        .mem_valid_o(mv[1]), .mem_ready_i(mem_ready), .mem_addr_o(ma[1]),
        .mem_wdata_o(wd_b), .mem_be_o(be_b), .done_o(dn[1]), .err_o(er[1]));

    store_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rr[2]),
        .funct3_i(f3), .addr_i(addr), .data_i(din),
        .mem_valid_o(mv[2]), .mem_ready_i(mem_ready), .mem_addr_o(ma[2]),
        .mem_wdata_o(wd_c), .mem_be_o(be_c), .done_o(dn[2]), .err_o(er[2]));

    function automatic logic [63:0] wd_of(input int k);
        case (k)
            0:       return {32'h0, wd_a};
            1:       return {32'h0, wd_b};
            default: return wd_c;
        endcase
    endfunction

    function automatic logic [7:0] be_of(input int k);
        case (k)
            0:       return {4'h0, be_a};
            1:       return {4'h0, be_b};
            default: return be_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte placement: each stored byte lands at absolute address addr+j.
    function automatic void model(input int k, input int xl, input bit allow,
                                  input logic [2:0] f, input logic [31:0] a, input logic [63:0] d);
        int nbw, sz, off, p, b, l;
        logic [31:0] base;
        nbw  = xl / 8;
        sz   = 1 << f[1:0];
        off  = int'(a % nbw);
        base = a - off;
        m_be[k][0] = 8'h0; m_be[k][1] = 8'h0;
        m_wd[k][0] = 64'h0; m_wd[k][1] = 64'h0;
        m_addr[k][0] = base;
        m_addr[k][1] = base + nbw;
        m_err[k] = f[2] || (f[1:0] == 2'b11 && xl == 32);
        m_nb[k]  = ((off + sz - 1) / nbw) + 1;
        if (m_nb[k] == 2 && !allow) m_err[k] = 1'b1;
        if (m_err[k]) begin
            m_nb[k] = 0;
        end else begin
            for (int j = 0; j < sz; j++) begin
                p = off + j;
                b = p / nbw;
                l = p % nbw;
                m_be[k][b][l] = 1'b1;
                m_wd[k][b][8*l +: 8] = d[8*j +: 8];
            end
        end
    endfunction

    task automatic do_store(input logic [2:0] f, input logic [31:0] a, input logic [63:0] d,
                            input int stall, input bit rnd);
        int cyc;
        bit busy;
        bit ev;
        model(0, 32, 1'b1, f, a, d);
        model(1, 32, 1'b0, f, a, d);
        model(2, 64, 1'b1, f, a, d);
        for (int k = 0; k < 3; k++) begin
            idx[k] = 0; done_p[k] = 1'b0; err_p[k] = m_err[k];
        end
        f3 = f; addr = a; din = d; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) chk($sformatf("req_ready_idle%0d", k), rr[k], 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        f3 = 3'($urandom_range(0, 7)); addr = $urandom; din = {$urandom, $urandom};
        cyc = 0; busy = 1'b1;
        while (busy && cyc < 40) begin
            for (int k = 0; k < 3; k++) begin
                ev = idx[k] < m_nb[k];
                chk($sformatf("valid%0d", k), mv[k], ev);
                chk($sformatf("ready%0d", k), rr[k], !ev);
                chk($sformatf("done%0d", k), dn[k], done_p[k]);
                chk($sformatf("err%0d", k), er[k], err_p[k]);
                if (ev) begin
                    chk($sformatf("addr%0d", k), ma[k], m_addr[k][idx[k]]);
                    chk($sformatf("be%0d", k), be_of(k), m_be[k][idx[k]]);
                    chk($sformatf("wdata%0d", k), wd_of(k), m_wd[k][idx[k]]);
                end
            end
            mem_ready = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(posedge clk);
            busy = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (idx[k] < m_nb[k] && mem_ready) begin
                    idx[k]++;
                    done_p[k] = (idx[k] == m_nb[k]);
                end else begin
                    done_p[k] = 1'b0;
                end
                err_p[k] = 1'b0;
                if (idx[k] < m_nb[k] || done_p[k]) busy = 1'b1;
            end
            #1;
            cyc++;
        end
        chk("timeout", busy, 0);
    endtask

    initial begin
        logic [2:0] rf;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), rr[k], 0);
            chk($sformatf("rst_valid%0d", k), mv[k], 0);
            chk($sformatf("rst_addr%0d", k), ma[k], 0);
            chk($sformatf("rst_be%0d", k), be_of(k), 0);
            chk($sformatf("rst_wdata%0d", k), wd_of(k), 0);
            chk($sformatf("rst_done%0d", k), dn[k], 0);
            chk($sformatf("rst_err%0d", k), er[k], 0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("post_rst_ready%0d", k), rr[k], 1);

        do_store(3'b010, 32'h0000_0100, 64'h0000_0000_DEAD_BEEF, 0, 1'b0);
        do_store(3'b000, 32'h0000_0103, 64'h0000_0000_1234_56AA, 0, 1'b0);
        do_store(3'b001, 32'h0000_0203, 64'h0000_0000_0000_1234, 0, 1'b0);
        do_store(3'b010, 32'h0000_0102, 64'h0000_0000_CAFE_F00D, 0, 1'b0);
        do_store(3'b011, 32'h0000_0040, 64'h0102_0304_0506_0708, 0, 1'b0);
        do_store(3'b010, 32'h0000_0010, 64'h0000_0000_A5A5_5A5A, 3, 1'b0);
        do_store(3'b010, 32'hFFFF_FFFE, 64'h0000_0000_8765_4321, 0, 1'b0);
        do_store(3'b011, 32'h0000_0FFD, 64'hFEDC_BA98_7654_3210, 2, 1'b0);
        do_store(3'b101, 32'h0000_0020, 64'h0000_0000_1111_2222, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rf = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            do_store(rf, $urandom, {$urandom, $urandom}, $urandom_range(0, 2), 1'b1);
        end

        // 64-bit split store interrupted by reset while the second beat is pending.
        mem_ready = 1'b1;
        f3 = 3'b011; addr = 32'h0000_0FFC; din = 64'h1122_3344_5566_7788; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sd_b1_valid", mv[2], 1);
        chk("sd_b1_addr", ma[2], 32'h0000_0FF8);
        chk("sd_b1_be", be_c, 8'hF0);
        chk("sd_b1_wdata", wd_c, 64'h5566_7788_0000_0000);
        @(posedge clk); #1;
        chk("sd_b2_valid", mv[2], 1);
        chk("sd_b2_addr", ma[2], 32'h0000_1000);
        chk("sd_b2_be", be_c, 8'h0F);
        chk("sd_b2_wdata", wd_c, 64'h0000_0000_1122_3344);
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_valid", mv[2], 0);
        chk("mid_rst_done", dn[2], 0);
        chk("mid_rst_ready", rr[2], 0);
        rst = 1'b0;
        #1;
        chk("after_rst_ready", rr[2], 1);
        @(posedge clk); #1;
        chk("after_rst_done", dn[2], 0);
        chk("after_rst_valid", mv[2], 0);

        do_store(3'b001, 32'h0000_0006, 64'h0000_0000_0000_BEEF, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
